// File: rtl/uart_axis_rx_fifo.sv
// uart_axis_rx_fifo: buffers UART receive characters and presents them as an AXI-Stream master.
// Define UART_AXIS_TLAST_EN to store a per-entry tlast bit set when the character equals EOP_CHAR.
module uart_axis_rx_fifo #(
    parameter int                   DATA_BITS = 8,
    parameter int                   DEPTH     = 16,
    parameter logic [DATA_BITS-1:0] EOP_CHAR  = 8'h0A
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_BITS-1:0]       rx_data,
    input  logic                       rx_valid,
    output logic [DATA_BITS-1:0]       m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 push, pop;

    always_comb begin
        pop        = (level_q != '0) && m_axis_tready;
        push       = rx_valid && ((level_q != FULL) || pop);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d    = level_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d = (rx_valid && !push) || (overflow_q && !ovf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    // Outputs are gated by tvalid so the unreset storage never shows during reset.
    assign m_axis_tvalid = level_q != '0;
    assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
    assign level         = level_q;
    assign overflow      = overflow_q;

`ifdef UART_AXIS_TLAST_EN
    logic last_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push) last_q[wr_ptr_q] <= rx_data == EOP_CHAR;
    end

    assign m_axis_tlast = m_axis_tvalid && last_q[rd_ptr_q];
`else
    logic unused_eop;

    assign unused_eop   = ^EOP_CHAR;
    assign m_axis_tlast = 1'b0;
`endif
endmodule

// File: tb/tb_uart_axis_rx_fifo.sv
// tb_uart_axis_rx_fifo: directed self-checking bench for uart_axis_rx_fifo at default parameters.
// Expected tlast follows UART_AXIS_TLAST_EN as seen by this bench's compile.
module tb_uart_axis_rx_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready = 1'b0;
    logic       tlast;
    logic [4:0] level;
    logic       overflow;
    logic       ovf_clr = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;

    uart_axis_rx_fifo dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_last(input logic [7:0] d);
`ifdef UART_AXIS_TLAST_EN
        return d == 8'h0A;
`else
        return d == 8'h0A && 1'b0;
`endif
    endfunction

    initial begin
        logic [7:0] q[$];
        logic       popx, acc;
        int         sent, rcv, gap, qn;
        #2;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", tlast, 0);
        tick();
        rst_n = 1'b1;
        tick();
        // single character, 1-cycle latency
        rx_valid = 1'b1; rx_data = 8'h55; tready = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("single_tvalid", tvalid, 1);
        chk("single_tdata", tdata, 8'h55);
        chk("single_level", level, 1);
        tick();
        chk("single_empty_tvalid", tvalid, 0);
        chk("single_empty_level", level, 0);
        tick();
        chk("underflow_level", level, 0);
        // fill to full, then drop
        tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i);
            tick();
        end
        chk("full_level", level, 16);
        chk("full_ovf_clear", overflow, 0);
        rx_data = 8'hAA;
        tick();
        chk("drop_level", level, 16);
        chk("drop_ovf", overflow, 1);
        chk("drop_tdata_stable", tdata, 8'h00);
        rx_data = 8'hBB; ovf_clr = 1'b1;
        tick();
        chk("drop_clr_ovf", overflow, 1);
        rx_valid = 1'b0;
        tick();
        ovf_clr = 1'b0;
        chk("clr_ovf", overflow, 0);
        // full with simultaneous push and pop
        chk("full_head", tdata, 8'h00);
        rx_valid = 1'b1; rx_data = 8'h77; tready = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("pushpop_full_level", level, 16);
        chk("pushpop_full_ovf", overflow, 0);
        for (int i = 1; i < 17; i++) begin
            chk("drain_data", tdata, i == 16 ? 8'h77 : 8'(i));
            chk("drain_valid", tvalid, 1);
            tick();
        end
        chk("drain_empty", level, 0);
        // end-of-packet marking
        tready = 1'b0;
        foreach (q[i]) q.delete();
        q.push_back(8'h41); q.push_back(8'h42); q.push_back(8'h0A);
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1; rx_data = q[i];
            tick();
        end
        rx_valid = 1'b0;
        tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("tlast_data", tdata, q[i]);
            chk("tlast_flag", tlast, exp_last(q[i]));
            tick();
        end
        chk("tlast_idle", tlast, 0);
        q.delete();
        // randomised spacing and back-pressure, scoreboard order check
        sent = 0; rcv = 0; gap = 0;
        for (int cyc = 0; cyc < 2000 && rcv < 40; cyc++) begin
            tready = 1'($urandom_range(0, 1));
            rx_valid = sent < 40 && gap == 0;
            rx_data = 8'(sent * 7 + 3);
            if (!rx_valid && gap > 0) gap--;
            qn = q.size();
            popx = tvalid && tready;
            acc = rx_valid && (qn < 16 || popx);
            if (popx) begin
                if (q.size() == 0) chk("rand_spurious", 1, 0);
                else begin
                    chk("rand_data", tdata, q[0]);
                    void'(q.pop_front());
                    rcv++;
                end
            end
            if (acc) begin
                q.push_back(rx_data);
                sent++;
                gap = $urandom_range(0, 2);
            end
            tick();
        end
        rx_valid = 1'b0;
        chk("rand_count", rcv, 40);
        chk("rand_level", level, 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        // asynchronous reset mid-transfer
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1; rx_data = 8'(8'hE0 + i);
            tick();
        end
        rx_valid = 1'b0;
        chk("pre_rst_level", level, 5);
        chk("pre_rst_tvalid", tvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", tvalid, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_ovf", overflow, 0);
        chk("async_rst_tdata", tdata, 0);
        tick();
        rst_n = 1'b1;
        tick();
        rx_valid = 1'b1; rx_data = 8'h33;
        tick();
        rx_valid = 1'b0;
        chk("post_rst_tdata", tdata, 8'h33);
        chk("post_rst_level", level, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_axis_rx_fifo.md
UART_AXIS_RX_FIFO -- requirements
Module: uart_axis_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the width of received characters and of m_axis_tdata.
REQ-002 Parameter DEPTH, default 16, SHALL set FIFO entries; legal values are powers of two from 2 to 256.
REQ-003 Parameter EOP_CHAR, default 8'h0A, SHALL set the end-of-packet character used by the TLAST feature.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 rx_data  input  DATA_BITS  SHALL carry the received character from the UART receiver.
REQ-007 rx_valid  input  1  SHALL be a one-cycle strobe marking rx_data valid.
REQ-008 m_axis_tdata  output  DATA_BITS  SHALL be the AXI-Stream data (oldest stored character).
REQ-009 m_axis_tvalid  output  1  SHALL be the AXI-Stream valid.
REQ-010 m_axis_tready  input  1  SHALL be the AXI-Stream ready from the consumer.
REQ-011 m_axis_tlast  output  1  SHALL mark the end-of-packet character.
REQ-012 level  output  $clog2(DEPTH)+1  SHALL report stored entry count, 0..DEPTH.
REQ-013 overflow  output  1  SHALL be a sticky flag for a dropped character.
REQ-014 ovf_clr  input  1  SHALL clear overflow when high for one cycle.

Function
REQ-015 Push = rx_valid && (level < DEPTH || pop); pop = m_axis_tvalid && m_axis_tready.
REQ-016 A pushed character SHALL appear on m_axis_tdata with m_axis_tvalid=1 on the cycle after the rx_valid strobe (1-cycle latency from an empty FIFO).
REQ-017 m_axis_tvalid SHALL equal (level != 0); m_axis_tdata and m_axis_tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-018 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-019 Push and pop in the same cycle SHALL leave level unchanged, including at level=DEPTH, where the push is accepted.
REQ-020 rx_valid at level=DEPTH without pop SHALL drop the character, leave FIFO contents unchanged, and set overflow on the next edge.
REQ-021 overflow SHALL hold until ovf_clr; a drop and an ovf_clr in the same cycle SHALL leave overflow=1.
REQ-022 Characters SHALL leave in arrival order; no character other than one dropped per REQ-020 SHALL be lost or duplicated.
REQ-023 At level=0, tready SHALL be ignored and level SHALL not underflow.

Reset
REQ-024 While rst_n=0, the block SHALL force pointers=0, level=0, overflow=0, m_axis_tvalid=0, m_axis_tlast=0, and m_axis_tdata=0, independent of clk.
REQ-025 Reset mid-transfer SHALL discard all stored characters; after release, the first rx_valid SHALL be handled as a push to an empty FIFO.
REQ-026 Storage array contents need no reset.

Configuration
REQ-027 Macro UART_AXIS_TLAST_EN defined: each entry SHALL store a tlast bit = (rx_data == EOP_CHAR) at push time, and m_axis_tlast SHALL present it with the data.
REQ-028 Macro UART_AXIS_TLAST_EN undefined: no tlast storage SHALL be built, and m_axis_tlast SHALL be constant 0.

Verification
REQ-029 Reset, then single rx_valid with rx_data=8'h55, tready=1 -> next cycle tvalid=1, tdata=8'h55; following cycle tvalid=0, level=0.
REQ-030 tready=0, push 16 bytes 8'h00..8'h0F, then push 8'hAA -> level=16, overflow=1, and drain yields 8'h00..8'h0F only.
REQ-031 level=16, tready=1 with same-cycle rx_valid 8'h77 -> level stays 16; 8'h77 emerges as the 17th word after 8'h00..8'h0F.
REQ-032 Push 40 bytes with random tready and rx_valid spacing >= 1 cycle -> output order matches input, no loss; pointers wrap twice.
REQ-033 UART_AXIS_TLAST_EN defined, push 8'h41, 8'h42, 8'h0A -> tlast=1 only with 8'h0A; macro undefined -> tlast=0 throughout.
REQ-034 rst_n low with level=5 and tvalid=1 -> tvalid=0, level=0, and overflow=0 immediately without a clock edge; after release, push 8'h33 -> tdata=8'h33.
